// File: rtl/ex_stage.sv
// Execute stage of a 5-stage pipeline: operand forwarding, 32-bit ALU and
// the EX/MEM pipeline register. There is no stall input; bubbles arrive as
// zeroed control bits and flow through unchanged.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ID_EX_rs_content,
    input  logic [31:0] ID_EX_rt_content,
    input  logic [31:0] ID_EX_immediate,
    input  logic [4:0]  ID_EX_rs,
    input  logic [4:0]  ID_EX_rt,
    input  logic [4:0]  ID_EX_rd,
    input  logic [2:0]  ID_EX_ALUop,
    input  logic        ID_EX_ALUsrc,
    input  logic        ID_EX_dst,
    input  logic        ID_EX_memread,
    input  logic        ID_EX_memwrite,
    input  logic        ID_EX_memtoreg,
    input  logic        ID_EX_regwrite,
    input  logic [31:0] M_WB_write_data,
    input  logic [4:0]  M_WB_write_reg,
    input  logic        M_WB_regwrite,
    output logic [31:0] EX_M_alu_result,
    output logic [31:0] EX_M_store_data,
    output logic [4:0]  EX_M_write_reg,
    output logic        EX_M_memread,
    output logic        EX_M_memwrite,
    output logic        EX_M_memtoreg,
    output logic        EX_M_regwrite
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_SLT  = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_SLTU = 3'b111;

    logic [31:0] alu_result_d, alu_result_q;
    logic [31:0] store_data_d, store_data_q;
    logic [4:0]  write_reg_d,  write_reg_q;
    logic        memread_d,    memread_q;
    logic        memwrite_d,   memwrite_q;
    logic        memtoreg_d,   memtoreg_q;
    logic        regwrite_d,   regwrite_q;

    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;
    logic [31:0] op_b;
    logic        exm_hit_rs, exm_hit_rt, mwb_hit_rs, mwb_hit_rt;

    // Hazard detection: register 0 is never a valid forwarding source.
    always_comb begin
        exm_hit_rs = regwrite_q && (write_reg_q != 5'd0) && (write_reg_q == ID_EX_rs);
        exm_hit_rt = regwrite_q && (write_reg_q != 5'd0) && (write_reg_q == ID_EX_rt);
        mwb_hit_rs = M_WB_regwrite && (M_WB_write_reg != 5'd0) && (M_WB_write_reg == ID_EX_rs);
        mwb_hit_rt = M_WB_regwrite && (M_WB_write_reg != 5'd0) && (M_WB_write_reg == ID_EX_rt);
    end

    // Operand muxes: the younger EX/MEM result wins over MEM/WB.
    always_comb begin
        fwd_rs = ID_EX_rs_content;
        fwd_rt = ID_EX_rt_content;
        if (exm_hit_rs) begin
            fwd_rs = alu_result_q;
        end else if (mwb_hit_rs) begin
            fwd_rs = M_WB_write_data;
        end else begin
            fwd_rs = ID_EX_rs_content;
        end
        if (exm_hit_rt) begin
            fwd_rt = alu_result_q;
        end else if (mwb_hit_rt) begin
            fwd_rt = M_WB_write_data;
        end else begin
            fwd_rt = ID_EX_rt_content;
        end
        if (ID_EX_ALUsrc) begin
            op_b = ID_EX_immediate;
        end else begin
            op_b = fwd_rt;
        end
    end

    // ALU plus next-state values for the EX/MEM register.
    always_comb begin
        alu_result_d = 32'd0;
        case (ID_EX_ALUop)
            OP_ADD:  alu_result_d = fwd_rs + op_b;
            OP_SUB:  alu_result_d = fwd_rs - op_b;
            OP_AND:  alu_result_d = fwd_rs & op_b;
            OP_OR:   alu_result_d = fwd_rs | op_b;
            OP_SLT:  alu_result_d = ($signed(fwd_rs) < $signed(op_b)) ? 32'd1 : 32'd0;
            OP_NOR:  alu_result_d = ~(fwd_rs | op_b);
            OP_XOR:  alu_result_d = fwd_rs ^ op_b;
            OP_SLTU: alu_result_d = (fwd_rs < op_b) ? 32'd1 : 32'd0;
            default: alu_result_d = 32'd0;
        endcase
        store_data_d = fwd_rt;
        if (ID_EX_dst) begin
            write_reg_d = ID_EX_rd;
        end else begin
            write_reg_d = ID_EX_rt;
        end
        memread_d  = ID_EX_memread;
        memwrite_d = ID_EX_memwrite;
        memtoreg_d = ID_EX_memtoreg;
        regwrite_d = ID_EX_regwrite;
    end

    // EX/MEM pipeline register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            alu_result_q <= 32'd0;
            store_data_q <= 32'd0;
            write_reg_q  <= 5'd0;
            memread_q    <= 1'b0;
            memwrite_q   <= 1'b0;
            memtoreg_q   <= 1'b0;
            regwrite_q   <= 1'b0;
        end else begin
            alu_result_q <= alu_result_d;
            store_data_q <= store_data_d;
            write_reg_q  <= write_reg_d;
            memread_q    <= memread_d;
            memwrite_q   <= memwrite_d;
            memtoreg_q   <= memtoreg_d;
            regwrite_q   <= regwrite_d;
        end
    end

    assign EX_M_alu_result = alu_result_q;
    assign EX_M_store_data = store_data_q;
    assign EX_M_write_reg  = write_reg_q;
    assign EX_M_memread    = memread_q;
    assign EX_M_memwrite   = memwrite_q;
    assign EX_M_memtoreg   = memtoreg_q;
    assign EX_M_regwrite   = regwrite_q;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: a behavioural model of the EX/MEM contents is compared
// against the DUT every cycle, and hand-computed values pin key scenarios.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rs_c, rt_c, imm;
    logic [4:0]  rs, rt, rd;
    logic [2:0]  aluop;
    logic        alusrc, dst, mr, mw, mt, rw;
    logic [31:0] wb_data;
    logic [4:0]  wb_reg;
    logic        wb_rw;
    logic [31:0] alu_result, store_data;
    logic [4:0]  write_reg;
    logic        memread, memwrite, memtoreg, regwrite;

    int checks = 0;
    int fails  = 0;
    bit model_valid = 1'b0;

    // Model state: what the EX/MEM register should hold.
    logic [31:0] m_res, m_st;
    logic [4:0]  m_wr;
    logic        m_mr, m_mw, m_mt, m_rw;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .rst(rst),
        .ID_EX_rs_content(rs_c), .ID_EX_rt_content(rt_c), .ID_EX_immediate(imm),
        .ID_EX_rs(rs), .ID_EX_rt(rt), .ID_EX_rd(rd),
        .ID_EX_ALUop(aluop), .ID_EX_ALUsrc(alusrc), .ID_EX_dst(dst),
        .ID_EX_memread(mr), .ID_EX_memwrite(mw), .ID_EX_memtoreg(mt), .ID_EX_regwrite(rw),
        .M_WB_write_data(wb_data), .M_WB_write_reg(wb_reg), .M_WB_regwrite(wb_rw),
        .EX_M_alu_result(alu_result), .EX_M_store_data(store_data),
        .EX_M_write_reg(write_reg), .EX_M_memread(memread), .EX_M_memwrite(memwrite),
        .EX_M_memtoreg(memtoreg), .EX_M_regwrite(regwrite)
    );

    // Value of a source register as seen by the instruction in EX.
    function automatic logic [31:0] read_src(input logic [4:0] idx, input logic [31:0] file_val);
        if (idx == 5'd0) return file_val;
        if (m_rw && m_wr == idx) return m_res;
        if (wb_rw && wb_reg == idx) return wb_data;
        return file_val;
    endfunction

    function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int signed sa, sb;
        sa = a;
        sb = b;
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return (sa < sb) ? 32'd1 : 32'd0;
            3'd5: return ~(a | b);
            3'd6: return a ^ b;
            default: return (a < b) ? 32'd1 : 32'd0;
        endcase
    endfunction

    // Advance the model at each rising edge from the current inputs.
    always @(posedge clk) begin
        logic [31:0] a, b;
        if (!rst) begin
            m_res <= 32'd0; m_st <= 32'd0; m_wr <= 5'd0;
            m_mr <= 1'b0; m_mw <= 1'b0; m_mt <= 1'b0; m_rw <= 1'b0;
            model_valid <= 1'b1;
        end else begin
            a = read_src(rs, rs_c);
            b = read_src(rt, rt_c);
            m_res <= alu(aluop, a, alusrc ? imm : b);
            m_st  <= b;
            m_wr  <= dst ? rd : rt;
            m_mr <= mr; m_mw <= mw; m_mt <= mt; m_rw <= rw;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (model_valid) begin
            checks++;
            if ({alu_result, store_data, write_reg, memread, memwrite, memtoreg, regwrite} !==
                {m_res, m_st, m_wr, m_mr, m_mw, m_mt, m_rw}) begin
                fails++;
                $display("FAIL model_cmp t=%0t got res=%h st=%h wr=%0d c=%b%b%b%b expected res=%h st=%h wr=%0d c=%b%b%b%b",
                         $time, alu_result, store_data, write_reg, memread, memwrite, memtoreg, regwrite,
                         m_res, m_st, m_wr, m_mr, m_mw, m_mt, m_rw);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic op(input logic [2:0] o, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                      input logic [31:0] sc, input logic [31:0] tc, input logic [31:0] im,
                      input logic src, input logic ds, input logic r, input logic w, input logic m,
                      input logic regw);
        aluop = o; rs = s; rt = t; rd = d; rs_c = sc; rt_c = tc; imm = im;
        alusrc = src; dst = ds; mr = r; mw = w; mt = m; rw = regw;
    endtask

    task automatic wb(input logic en, input logic [4:0] r, input logic [31:0] data);
        wb_rw = en; wb_reg = r; wb_data = data;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        wb(1'b1, 5'd1, 32'hDEAD_BEEF);
        op(3'd0, 5'd1, 5'd2, 5'd7, 32'h5, 32'h7, 32'h3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step();
        // Reset with live inputs clears everything.
        chk("rst_result", alu_result, 32'd0);
        chk("rst_ctrl", {27'd0, write_reg}, {27'd0, 5'd0});
        chk("rst_regwrite", {31'd0, regwrite}, 32'd0);
        chk("rst_memwrite", {31'd0, memwrite}, 32'd0);
        // First valid capture: 5+7.
        rst = 1'b1;
        wb(1'b0, 5'd0, 32'd0);
        op(3'd0, 5'd1, 5'd2, 5'd7, 32'h5, 32'h7, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("add_5_7", alu_result, 32'd12);
        // EX/MEM forward on rs.
        op(3'd0, 5'd9, 5'd0, 5'd3, 32'h10, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        chk("wr_r3", {27'd0, write_reg}, {27'd0, 5'd3});
        op(3'd0, 5'd3, 5'd0, 5'd8, 32'h99, 32'h0, 32'h1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("fwd_exm_rs", alu_result, 32'h11);
        // EX/MEM beats MEM/WB on rt.
        op(3'd0, 5'd6, 5'd0, 5'd4, 32'hA, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        wb(1'b1, 5'd4, 32'hB);
        op(3'd1, 5'd7, 5'd4, 5'd10, 32'h20, 32'h77, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("fwd_priority", alu_result, 32'h16);
        chk("fwd_priority_st", store_data, 32'hA);
        // MEM/WB-only forward on rs.
        op(3'd0, 5'd4, 5'd0, 5'd11, 32'h1, 32'h0, 32'h2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("fwd_mwb_rs", alu_result, 32'hD);
        // Register 0 never forwards.
        wb(1'b1, 5'd0, 32'h66);
        op(3'd0, 5'd9, 5'd0, 5'd0, 32'h55, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        chk("r0_write_val", alu_result, 32'h55);
        op(3'd0, 5'd0, 5'd0, 5'd12, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("r0_guard", alu_result, 32'd0);
        // Arithmetic corner cases, no forwarding active.
        wb(1'b0, 5'd0, 32'd0);
        op(3'd4, 5'd8, 5'd9, 5'd1, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("slt", alu_result, 32'd1);
        op(3'd7, 5'd8, 5'd9, 5'd1, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("sltu", alu_result, 32'd0);
        op(3'd0, 5'd8, 5'd9, 5'd1, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("add_wrap", alu_result, 32'd0);
        op(3'd5, 5'd8, 5'd9, 5'd1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("nor", alu_result, 32'hFFFF_FFFF);
        op(3'd1, 5'd8, 5'd9, 5'd1, 32'h0, 32'h1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("sub_wrap", alu_result, 32'hFFFF_FFFF);
        op(3'd2, 5'd8, 5'd9, 5'd1, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("and", alu_result, 32'h00F0_1200);
        op(3'd3, 5'd8, 5'd9, 5'd1, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("or", alu_result, 32'hFFF0_FF34);
        op(3'd6, 5'd8, 5'd9, 5'd1, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("xor", alu_result, 32'hFF00_ED34);
        op(3'd4, 5'd8, 5'd9, 5'd1, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("slt_pos_neg", alu_result, 32'd0);
        // Store with rt forwarded from MEM/WB.
        wb(1'b1, 5'd5, 32'h1234);
        op(3'd0, 5'd10, 5'd5, 5'd0, 32'h100, 32'hDEAD, 32'h4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        chk("store_addr", alu_result, 32'h104);
        chk("store_data", store_data, 32'h1234);
        chk("store_memwrite", {31'd0, memwrite}, 32'd1);
        chk("store_wr_rt", {27'd0, write_reg}, {27'd0, 5'd5});
        // Bubble propagates as zeroed control.
        wb(1'b0, 5'd0, 32'd0);
        op(3'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("bubble_ctrl", {28'd0, memread, memwrite, memtoreg, regwrite}, 32'd0);
        // Load control passes through.
        op(3'd0, 5'd2, 5'd13, 5'd0, 32'h40, 32'h0, 32'h8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        chk("load_ctrl", {28'd0, memread, memwrite, memtoreg, regwrite}, 32'hB);
        // Mid-run reset discards the instruction; no forward afterwards.
        op(3'd0, 5'd9, 5'd0, 5'd14, 32'h77, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        step();
        chk("midrst_result", alu_result, 32'd0);
        rst = 1'b1;
        op(3'd0, 5'd13, 5'd0, 5'd2, 32'h3, 32'h0, 32'h1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("post_rst_nofwd", alu_result, 32'h4);
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have no parameters; datapath width fixed at 32 bits, register index at 5 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low; sampled only on rising clk.
REQ-004 ID_EX_rs_content  input  32  rs operand from ID/EX register.
REQ-005 ID_EX_rt_content  input  32  rt operand from ID/EX register.
REQ-006 ID_EX_immediate  input  32  immediate, already sign-extended by ID/EX.
REQ-007 ID_EX_rs, ID_EX_rt, ID_EX_rd  input  5 each  source/destination indices.
REQ-008 ID_EX_ALUop  input  3  ALU operation select.
REQ-009 ID_EX_ALUsrc, ID_EX_dst  input  1 each  operand-B select (1=immediate), destination select (1=rd).
REQ-010 ID_EX_memread, ID_EX_memwrite, ID_EX_memtoreg, ID_EX_regwrite  input  1 each  control passed to MEM/WB.
REQ-011 M_WB_write_data  input  32  writeback value, forwarding source 2.
REQ-012 M_WB_write_reg  input  5  writeback destination index.
REQ-013 M_WB_regwrite  input  1  writeback enable.
REQ-014 EX_M_alu_result  output  32  registered ALU result (memory address or writeback value).
REQ-015 EX_M_store_data  output  32  registered forwarded rt value for stores.
REQ-016 EX_M_write_reg  output  5  registered destination index.
REQ-017 EX_M_memread, EX_M_memwrite, EX_M_memtoreg, EX_M_regwrite  output  1 each  registered control.

Function
REQ-018 SHALL compute write register combinationally: ID_EX_dst=1 -> ID_EX_rd, else ID_EX_rt.
REQ-019 Forward A: if EX_M_regwrite and EX_M_write_reg!=0 and EX_M_write_reg==ID_EX_rs -> EX_M_alu_result; else if M_WB_regwrite and M_WB_write_reg!=0 and M_WB_write_reg==ID_EX_rs -> M_WB_write_data; else ID_EX_rs_content.
REQ-020 Forward B: same rule against ID_EX_rt, producing fwd_rt; EX/MEM match SHALL take priority over MEM/WB when both match.
REQ-021 Register 0 SHALL never be a forwarding source, regardless of regwrite.
REQ-022 Operand B = ID_EX_immediate when ID_EX_ALUsrc=1, else fwd_rt; store data SHALL always be fwd_rt.
REQ-023 ALUop: 000 add, 001 sub, 010 and, 011 or, 100 slt (signed, result 1 or 0), 101 nor, 110 xor, 111 sltu (unsigned).
REQ-024 add/sub SHALL wrap modulo 2^32; overflow SHALL not be flagged or trapped.
REQ-025 EX/MEM register SHALL load ALU result, store data, write register and four control bits every rising clk when rst=1; latency exactly one cycle.
REQ-026 No enable/stall input: a bubble arrives as zeroed control from ID/EX and SHALL propagate as EX_M_regwrite=0, EX_M_memwrite=0, EX_M_memread=0.
REQ-027 Forwarding SHALL use current registered EX_M_* outputs, so back-to-back dependent ALU instructions need no stall.
REQ-028 Load-use dependency is not resolved here; upstream hazard unit inserts the bubble.

Reset
REQ-029 When rst=0 at a rising edge, all EX_M_* outputs SHALL become 0 that cycle, overriding any incoming data.
REQ-030 An instruction in EX during reset SHALL be discarded; first valid capture is the first edge with rst=1.
REQ-031 Forwarding after reset SHALL see EX_M_regwrite=0 (no spurious forward from EX/MEM).

Verification
REQ-032 Reset: rst=0 one edge with live inputs -> all EX_M_* = 0; rst=1 next edge, add 5+7 -> EX_M_alu_result=12.
REQ-033 EX/MEM forward: EX_M writes r3=0x10; next op rs=3, rs_content=0x99, add imm 1 -> result 0x11.
REQ-034 Priority: EX_M r4=0xA, M_WB r4=0xB, op rt=4 sub from rs_content 0x20 -> result 0x16.
REQ-035 r0 guard: EX_M_regwrite=1, EX_M_write_reg=0, value 0x55; op rs=0, rs_content=0 add imm 0 -> result 0.
REQ-036 Arithmetic: slt 0xFFFFFFFF,1 -> 1; sltu same -> 0; add 0xFFFFFFFF+1 -> 0; nor 0,0 -> 0xFFFFFFFF.
REQ-037 Store: memwrite=1, ALUsrc=1, rt forwarded from M_WB 0x1234, base 0x100 + imm 4 -> alu_result 0x104, store_data 0x1234.
